m_bus_arbiter: RTL

- Arbitrates the single data-memory/timer bus between the CPU M-stage load/store port (already byte-enabled and aligned) and a secondary master (debug/DMA).
- Decodes the target (DM, TC0, TC1), sequences one outstanding transaction with a fixed read latency, and returns an ack, read data and an access error.
- Sits between the M-stage byte-enable logic and the DM/timer bridge. The CPU stalls on `o_cpu_stall`.

---
 rtl/m_bus_arbiter_pkg.sv | 33 +++
 rtl/m_addr_decode.sv | 26 ++
 rtl/m_bus_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/m_bus_arbiter_pkg.sv
// Shared encodings and address-window constants for the M-stage / debug bus arbiter.
package m_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_DM   = 3'b001;
  localparam logic [2:0] SEL_TC0  = 3'b010;
  localparam logic [2:0] SEL_TC1  = 3'b100;

  localparam logic [31:0] DM_END_DEF    = 32'h0000_2fff;
  localparam logic [31:0] TC0_BEGIN_DEF = 32'h0000_7f00;
  localparam logic [31:0] TC1_BEGIN_DEF = 32'h0000_7f10;
  localparam logic [31:0] TC_WIN_BYTES  = 32'd12;

  // Window end is formed in 33 bits so a base near the top of memory cannot wrap.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    logic [32:0] last;
    last = {1'b0, base} + {1'b0, TC_WIN_BYTES} - 33'd1;
    return (addr >= base) && ({1'b0, addr} <= last);
  endfunction

endpackage

// File: rtl/m_addr_decode.sv
// Combinational target decode: DM, TC0 or TC1 as a one-hot select, or a miss.
module m_addr_decode
  import m_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] DM_END    = DM_END_DEF,
  parameter logic [31:0] TC0_BEGIN = TC0_BEGIN_DEF,
  parameter logic [31:0] TC1_BEGIN = TC1_BEGIN_DEF
) (
  input  logic [31:0] addr,
  output logic [2:0]  sel,
  output logic        miss
);

  always_comb begin
    sel = SEL_NONE;
    if (addr <= DM_END) begin
      sel = SEL_DM;
    end else if (in_window(addr, TC0_BEGIN)) begin
      sel = SEL_TC0;
    end else if (in_window(addr, TC1_BEGIN)) begin
      sel = SEL_TC1;
    end
    miss = (sel == SEL_NONE);
  end

endmodule

// File: rtl/m_bus_arbiter.sv
// Round-robin arbiter between the CPU M-stage port and a debug/DMA master,
// running one fixed-latency transaction at a time on the DM/timer bus.
module m_bus_arbiter
  import m_bus_arbiter_pkg::*;
#(
  parameter int unsigned RD_LAT    = 1,
  parameter logic [31:0] DM_END    = DM_END_DEF,
  parameter logic [31:0] TC0_BEGIN = TC0_BEGIN_DEF,
  parameter logic [31:0] TC1_BEGIN = TC1_BEGIN_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  input  logic [3:0]  i_cpu_byteen,
  output logic        o_cpu_ack,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_stall,
  input  logic        i_dbg_req,
  input  logic        i_dbg_we,
  input  logic [31:0] i_dbg_addr,
  input  logic [31:0] i_dbg_wdata,
  input  logic [3:0]  i_dbg_byteen,
  output logic        o_dbg_ack,
  output logic [31:0] o_dbg_rdata,
  output logic        o_err,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [2:0]  o_mem_sel,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_byteen,
  input  logic [31:0] i_mem_rdata
);

  arb_state_t  state_q, state_d;
  owner_t      owner_q, last_grant_q, winner;
  logic        we_q, miss_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  byteen_q;
  logic [2:0]  sel_q, cnt_q;
  logic        req_any, pick_dbg, dec_miss, cpu_ack;
  logic [31:0] req_addr;
  logic [2:0]  dec_sel;

  // On a tie the master that did not win last time gets the bus.
  assign req_any  = i_cpu_req | i_dbg_req;
  assign pick_dbg = i_dbg_req & (~i_cpu_req | (last_grant_q == OWN_CPU));
  assign winner   = pick_dbg ? OWN_DBG : OWN_CPU;
  assign req_addr = pick_dbg ? i_dbg_addr : i_cpu_addr;

  m_addr_decode #(
    .DM_END   (DM_END),
    .TC0_BEGIN(TC0_BEGIN),
    .TC1_BEGIN(TC1_BEGIN)
  ) u_decode (
    .addr(req_addr),
    .sel (dec_sel),
    .miss(dec_miss)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (req_any) state_d = dec_miss ? ARB_DONE : ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT:  if (cnt_q == 3'd1) state_d = ARB_DONE;
      ARB_DONE:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_DBG;
      we_q         <= 1'b0;
      miss_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      byteen_q     <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ARB_IDLE: begin
          if (req_any) begin
            owner_q  <= winner;
            we_q     <= pick_dbg ? i_dbg_we : i_cpu_we;
            addr_q   <= req_addr;
            wdata_q  <= pick_dbg ? i_dbg_wdata : i_cpu_wdata;
            byteen_q <= pick_dbg ? i_dbg_byteen : i_cpu_byteen;
            sel_q    <= dec_sel;
            miss_q   <= dec_miss;
          end
        end
        ARB_ISSUE: cnt_q <= 3'(RD_LAT);
        ARB_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1 && !we_q) rdata_q <= i_mem_rdata;
        end
        ARB_DONE: last_grant_q <= owner_q;
        default: ;
      endcase
    end
  end

  // Bus side is quiet outside ISSUE so the bridge sees exactly one strobe.
  always_comb begin
    o_mem_en     = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_sel    = '0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_mem_byteen = '0;
    if (state_q == ARB_ISSUE) begin
      o_mem_en     = 1'b1;
      o_mem_we     = we_q;
      o_mem_sel    = sel_q;
      o_mem_addr   = addr_q;
      o_mem_wdata  = wdata_q;
      o_mem_byteen = we_q ? byteen_q : 4'h0;
    end
  end

  assign cpu_ack     = (state_q == ARB_DONE) && (owner_q == OWN_CPU);
  assign o_cpu_ack   = cpu_ack;
  assign o_dbg_ack   = (state_q == ARB_DONE) && (owner_q == OWN_DBG);
  assign o_err       = (state_q == ARB_DONE) && miss_q;
  assign o_cpu_rdata = rdata_q;
  assign o_dbg_rdata = rdata_q;
  assign o_cpu_stall = i_cpu_req & ~cpu_ack;

endmodule
